timer_cmp: RTL and testbench



---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_cmp_match.sv | 15 +
 rtl/timer_cmp.sv | 165 ++++++++++++++++
 tb/tb_timer_cmp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register offsets, CTRL bit positions and FSM state type for the timer compare stage.
`ifndef BASE_TIMER0
`define BASE_TIMER0 32'h4000_0000
`endif

package timer_pkg;

  localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
  localparam logic [31:0] OFF_CMP     = 32'h0000_0004;
  localparam logic [31:0] OFF_PERIOD  = 32'h0000_0008;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_000C;
  localparam logic [31:0] OFF_FIRECNT = 32'h0000_0010;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;

  typedef enum logic [1:0] {
    TC_IDLE  = 2'd0,
    TC_ARMED = 2'd1,
    TC_FIRED = 2'd2
  } tcmp_state_e;

endpackage

// File: rtl/timer_cmp_match.sv
// Wrap-safe compare: hit when (value - cmp) mod 2^CNT_W is non-negative as a signed number.
module timer_cmp_match #(
  parameter int CNT_W = 32
) (
  input  logic [CNT_W-1:0] value,
  input  logic [CNT_W-1:0] cmp,
  output logic             hit_raw
);

  logic [CNT_W-1:0] diff_s;

  assign diff_s  = value - cmp;
  assign hit_raw = ~diff_s[CNT_W-1];

endmodule

// File: rtl/timer_cmp.sv
// Compare/interrupt stage for the free-running timer: one-shot or periodic compare with level IRQ.
// Optional saturating hit counter at FIRE_CNT is built when TIMER_CMP_FIRECNT_EN is defined.
module timer_cmp
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = `BASE_TIMER0 + 32'h10,
  parameter int          CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic [CNT_W-1:0] i_timer_value,
  output logic             o_irq
);

  logic [2:0]       ctrl_r;
  logic [CNT_W-1:0] cmp_r;
  logic [CNT_W-1:0] period_r;
  logic             pend_r;
  logic             missed_r;
  logic             irq_r;
  tcmp_state_e      state_r;

  logic sel_ctrl_s, sel_cmp_s, sel_period_s, sel_status_s, sel_firecnt_s;
  logic wr_ctrl_s, wr_cmp_s, wr_period_s, wr_status_s;
  logic hit_raw_s, hit_s, advance_s;
  logic pend_nxt_s, missed_nxt_s;
  logic [2:0]       ctrl_nxt_s;
  tcmp_state_e      state_nxt_s;
  logic [31:0]      fire_cnt_rd_s;
  logic [31:0]      rdata_s;

  assign sel_ctrl_s    = (i_addr == BASE_ADDR + OFF_CTRL);
  assign sel_cmp_s     = (i_addr == BASE_ADDR + OFF_CMP);
  assign sel_period_s  = (i_addr == BASE_ADDR + OFF_PERIOD);
  assign sel_status_s  = (i_addr == BASE_ADDR + OFF_STATUS);
  assign sel_firecnt_s = (i_addr == BASE_ADDR + OFF_FIRECNT);

  assign wr_ctrl_s   = i_we & sel_ctrl_s;
  assign wr_cmp_s    = i_we & sel_cmp_s;
  assign wr_period_s = i_we & sel_period_s;
  assign wr_status_s = i_we & sel_status_s;

  timer_cmp_match #(.CNT_W(CNT_W)) u_match (
    .value   (i_timer_value),
    .cmp     (cmp_r),
    .hit_raw (hit_raw_s)
  );

  // A CMP write discards a same-cycle hit, including its auto-advance.
  assign hit_s     = (state_r == TC_ARMED) & hit_raw_s & ~wr_cmp_s;
  assign advance_s = hit_s & ctrl_r[CTRL_PERIODIC] & (period_r != {CNT_W{1'b0}});

  // Next-state, control and sticky status updates.
  always_comb begin
    state_nxt_s  = state_r;
    ctrl_nxt_s   = ctrl_r;
    pend_nxt_s   = pend_r;
    missed_nxt_s = missed_r;

    if (wr_ctrl_s) begin
      ctrl_nxt_s  = i_wdata[2:0];
      state_nxt_s = i_wdata[CTRL_EN] ? TC_ARMED : TC_IDLE;
    end else begin
      ctrl_nxt_s = ctrl_r;
      case (state_r)
        TC_IDLE:  state_nxt_s = TC_IDLE;
        TC_ARMED: state_nxt_s = (hit_s && !advance_s) ? TC_FIRED : TC_ARMED;
        TC_FIRED: state_nxt_s = wr_cmp_s ? TC_ARMED : TC_FIRED;
        default:  state_nxt_s = TC_IDLE;
      endcase
    end

    // Set beats W1C; an overrun only counts if PEND is not being cleared in the same cycle.
    if (hit_s) begin
      pend_nxt_s = 1'b1;
    end else if (wr_status_s && i_wdata[0]) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end

    if (hit_s && pend_r && !(wr_status_s && i_wdata[0])) begin
      missed_nxt_s = 1'b1;
    end else if (wr_status_s && i_wdata[1]) begin
      missed_nxt_s = 1'b0;
    end else begin
      missed_nxt_s = missed_r;
    end
  end

  // Register file, FSM state and registered interrupt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_r   <= 3'b000;
      cmp_r    <= {CNT_W{1'b1}};
      period_r <= {CNT_W{1'b0}};
      pend_r   <= 1'b0;
      missed_r <= 1'b0;
      irq_r    <= 1'b0;
      state_r  <= TC_IDLE;
    end else begin
      ctrl_r   <= ctrl_nxt_s;
      pend_r   <= pend_nxt_s;
      missed_r <= missed_nxt_s;
      irq_r    <= pend_nxt_s & ctrl_nxt_s[CTRL_IE];
      state_r  <= state_nxt_s;
      if (wr_cmp_s) begin
        cmp_r <= i_wdata[CNT_W-1:0];
      end else if (advance_s) begin
        cmp_r <= cmp_r + period_r;
      end
      if (wr_period_s) begin
        period_r <= i_wdata[CNT_W-1:0];
      end
    end
  end

`ifdef TIMER_CMP_FIRECNT_EN
  logic [31:0] fire_cnt_r;
  logic        wr_firecnt_s;

  assign wr_firecnt_s = i_we & sel_firecnt_s;

  // Saturating hit counter; a write clears it even against a same-cycle hit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fire_cnt_r <= 32'h0000_0000;
    end else if (wr_firecnt_s) begin
      fire_cnt_r <= 32'h0000_0000;
    end else if (hit_s && (fire_cnt_r != 32'hFFFF_FFFF)) begin
      fire_cnt_r <= fire_cnt_r + 32'd1;
    end
  end

  assign fire_cnt_rd_s = fire_cnt_r;
`else
  assign fire_cnt_rd_s = 32'h0000_0000;
`endif

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel_ctrl_s) begin
      rdata_s = {29'h0, ctrl_r};
    end else if (sel_cmp_s) begin
      rdata_s = 32'(cmp_r);
    end else if (sel_period_s) begin
      rdata_s = 32'(period_r);
    end else if (sel_status_s) begin
      rdata_s = {28'h0, state_r, missed_r, pend_r};
    end else if (sel_firecnt_s) begin
      rdata_s = fire_cnt_rd_s;
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign o_rdata = rdata_s;
  assign o_irq   = irq_r;

endmodule

// File: tb/tb_timer_cmp.sv
// Self-checking bench for timer_cmp: expected hit values are queued per scenario and matched by a monitor.
`ifndef BASE_TIMER0
`define BASE_TIMER0 32'h4000_0000
`endif

module tb_timer_cmp;
  import timer_pkg::*;

  localparam logic [31:0] BASE      = `BASE_TIMER0 + 32'h10;
  localparam logic [31:0] A_CTRL    = BASE + 32'h00;
  localparam logic [31:0] A_CMP     = BASE + 32'h04;
  localparam logic [31:0] A_PERIOD  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS  = BASE + 32'h0C;
  localparam logic [31:0] A_FIRECNT = BASE + 32'h10;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic [31:0] i_timer_value;
  logic        o_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  timer_cmp dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_we          (i_we),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .o_rdata       (o_rdata),
    .i_timer_value (i_timer_value),
    .o_irq         (o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    i_addr = a;
    #1;
    d = o_rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_we = 1'b1; i_addr = a; i_wdata = d;
    @(posedge i_clk); #1;
    i_we = 1'b0; i_wdata = 32'h0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // Steps the timer one value per cycle; any observed hit is popped against the expected queue.
  task automatic run_timer(input logic [31:0] start, input int n);
    logic [31:0] c0, s0, c1, s1, v, e;
    logic hit;
    rd(A_CMP, c0); rd(A_STATUS, s0);
    for (int i = 0; i < n; i++) begin
      v = start + 32'(i);
      i_timer_value = v;
      @(posedge i_clk); #1;
      rd(A_CMP, c1); rd(A_STATUS, s1);
      hit = (s1[0] & ~s0[0]) | (c1 != c0) | ((s1[3:2] == 2'd2) && (s0[3:2] == 2'd1));
      if (hit) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL hit_unexpected at value %0h, required no hit", v);
        end else begin
          e = exp_q.pop_front();
          if (v !== e) begin errors++; $display("FAIL hit_value got %0h required %0h", v, e); end
        end
      end
      c0 = c1; s0 = s1;
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_missing_hits got %0d pending required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    i_rst = 1'b1; i_we = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_timer_value = 32'h0;
    repeat (2) @(posedge i_clk);
    #1; i_rst = 1'b0;
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b required 0", o_irq); end
    rd(A_CTRL, d);    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %0h required 0", d); end
    rd(A_CMP, d);     checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got %0h required ffffffff", d); end
    rd(A_PERIOD, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_period got %0h required 0", d); end
    rd(A_STATUS, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %0h required 0", d); end
    rd(A_FIRECNT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_firecnt got %0h required 0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    do_reset();
    i_timer_value = 32'd0;
    wr(A_CMP, 32'd100);
    wr(A_CTRL, 32'h5);
    exp_q.push_back(32'd100);
    run_timer(32'd0, 100);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_early got %0b required 0", o_irq); end
    run_timer(32'd100, 1);
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %0b required 1", o_irq); end
    rd(A_STATUS, d);
    checks++; if (d[3:2] !== 2'd2) begin errors++; $display("FAIL oneshot_state got %0d required 2", d[3:2]); end
    wr(A_STATUS, 32'h1);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL oneshot_clear got %0b required 0", o_irq); end
    run_timer(32'd101, 10);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL oneshot_refire got %0b required 0", o_irq); end
    check_drained("oneshot");
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    do_reset();
    i_timer_value = 32'd0;
    wr(A_CMP, 32'd50);
    wr(A_PERIOD, 32'd20);
    wr(A_CTRL, 32'h7);
    exp_q.push_back(32'd50); exp_q.push_back(32'd70); exp_q.push_back(32'd90);
    run_timer(32'd0, 51);
    rd(A_STATUS, d);
    checks++; if (d[1] !== 1'b0) begin errors++; $display("FAIL periodic_missed_first got %0b required 0", d[1]); end
    run_timer(32'd51, 20);
    rd(A_STATUS, d);
    checks++; if (d[1] !== 1'b1) begin errors++; $display("FAIL periodic_missed got %0b required 1", d[1]); end
    run_timer(32'd71, 20);
    rd(A_CMP, d);
    checks++; if (d !== 32'd110) begin errors++; $display("FAIL periodic_cmp got %0d required 110", d); end
    check_drained("periodic");
  endtask

  task automatic test_firecnt();
    logic [31:0] d;
`ifdef TIMER_CMP_FIRECNT_EN
    rd(A_FIRECNT, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL firecnt_count got %0d required 3", d); end
    wr(A_FIRECNT, 32'h1234);
    rd(A_FIRECNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL firecnt_clear got %0d required 0", d); end
`else
    wr(A_FIRECNT, 32'h1234);
    rd(A_FIRECNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL firecnt_absent got %0h required 0", d); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    do_reset();
    i_timer_value = 32'hFFFF_FFFE;
    wr(A_CMP, 32'h5);
    wr(A_CTRL, 32'h1);
    exp_q.push_back(32'h5);
    run_timer(32'hFFFF_FFFE, 9);
    check_drained("wrap");
    rd(A_STATUS, d);
    checks++; if (d[3:2] !== 2'd2) begin errors++; $display("FAIL wrap_state got %0d required 2", d[3:2]); end
    wr(A_STATUS, 32'h3);
    i_timer_value = 32'd1000;
    wr(A_CMP, 32'd10);
    exp_q.push_back(32'd1000);
    run_timer(32'd1000, 1);
    rd(A_STATUS, d);
    checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL behind_pend got %0b required 1", d[0]); end
    check_drained("behind");
  endtask

  task automatic test_collision_cmp();
    logic [31:0] d;
    do_reset();
    i_timer_value = 32'd0;
    wr(A_CMP, 32'd20);
    wr(A_CTRL, 32'h1);
    run_timer(32'd0, 20);
    i_timer_value = 32'd20;
    wr(A_CMP, 32'd500);
    rd(A_STATUS, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL cmpwr_status got %0h required 4", d); end
    rd(A_CMP, d);
    checks++; if (d !== 32'd500) begin errors++; $display("FAIL cmpwr_cmp got %0d required 500", d); end
    check_drained("cmpwr");
  endtask

  task automatic test_collision_w1c();
    logic [31:0] d;
    do_reset();
    i_timer_value = 32'd0;
    wr(A_CMP, 32'd20);
    wr(A_PERIOD, 32'd10);
    wr(A_CTRL, 32'h7);
    exp_q.push_back(32'd20);
    run_timer(32'd0, 21);
    check_drained("w1c_setup");
    i_timer_value = 32'd30;
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL w1c_status got %0h required 5", d); end
    rd(A_CMP, d);
    checks++; if (d !== 32'd40) begin errors++; $display("FAIL w1c_cmp got %0d required 40", d); end
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL w1c_irq got %0b required 1", o_irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    i_timer_value = 32'd40;
    i_rst = 1'b1; i_we = 1'b1; i_addr = A_CTRL; i_wdata = 32'h7;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_we = 1'b0; i_wdata = 32'h0;
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got %0b required 0", o_irq); end
    rd(A_CTRL, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_ctrl got %0h required 0", d); end
    rd(A_CMP, d);    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_cmp got %0h required ffffffff", d); end
    rd(A_STATUS, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_status got %0h required 0", d); end
    rd(32'h24, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_24 got %0h required 0", d); end
    rd(BASE + 32'h14, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_base14 got %0h required 0", d); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_firecnt();
    test_wrap();
    test_collision_cmp();
    test_collision_w1c();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
